// File: rtl/prbs_checker_multi.sv
// prbs_checker_multi: multi-lane, self-synchronising PRBS checker.
// Consumes one n_channels-bit word per clock (bit 0 earliest). The PRBS tap
// mask is programmable at run time. The checker fills its history, searches
// for lock and then counts bit errors and checked bits in saturating
// counters. It detects loss of lock, counts each loss event and re-acquires
// lock automatically.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   prbs_eqn         tap mask, bit k => b[n-k] feeds the prediction (bit 0 unused)
//   checker_mode     0=RESET 1=ALIGN 2=RUN 3=FREEZE (registered internally)
//   rx_bits/rx_valid received word and its qualifier
//   lock_thresh      consecutive clean words needed for lock (0 acts as 1)
//   unlock_thresh    consecutive bad words needed to drop lock (0 acts as 1)
//   err_flags        per-bit error flags of the last processed word
//   err_bits         accumulated bit errors (saturating)
//   total_bits       accumulated checked bits (saturating)
//   locked           checker is aligned
//   loss_cnt         lock->unlock events (saturating)
module prbs_checker_multi #(
  parameter int n_prbs     = 32,
  parameter int n_channels = 16,
  parameter int n_cnt      = 64,
  parameter int n_thresh   = 8,
  parameter int n_loss     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [n_prbs-1:0]     prbs_eqn,
  input  logic [1:0]            checker_mode,
  input  logic [n_channels-1:0] rx_bits,
  input  logic                  rx_valid,
  input  logic [n_thresh-1:0]   lock_thresh,
  input  logic [n_thresh-1:0]   unlock_thresh,
  output logic [n_channels-1:0] err_flags,
  output logic [n_cnt-1:0]      err_bits,
  output logic [n_cnt-1:0]      total_bits,
  output logic                  locked,
  output logic [n_loss-1:0]     loss_cnt
);
  localparam int NH         = n_prbs - 1;
  localparam int NC         = n_channels;
  localparam int FILL_RAW   = (NH + NC - 1) / NC;
  localparam int FILL_WORDS = (FILL_RAW < 1) ? 1 : FILL_RAW;
  localparam int NF         = $clog2(FILL_WORDS + 1);
  localparam int PCW        = $clog2(NC + 1);

  localparam logic [1:0] MODE_RESET  = 2'd0;
  localparam logic [1:0] MODE_RUN    = 2'd2;
  localparam logic [1:0] MODE_FREEZE = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SEARCH, S_LOCKED, S_FROZEN} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q;
  logic [NH-1:0]       hist_q, hist_d;
  logic [NF-1:0]       fill_q, fill_d;
  logic [n_thresh-1:0] run_q, run_d, run_inc, lock_eff, unlock_eff;
  logic [NC-1:0]       err_flags_q, err_flags_d, pred, errs;
  logic [n_cnt-1:0]    err_bits_q, err_bits_d, total_bits_q, total_bits_d;
  logic                locked_q, locked_d;
  logic [n_loss-1:0]   loss_cnt_q, loss_cnt_d;
  logic [NH+NC-1:0]    ext;
  logic [PCW-1:0]      err_pc;
  logic [n_cnt:0]      err_sum, tot_sum;
  logic                bad;
  logic                eqn0_unused;

  assign eqn0_unused = prbs_eqn[0];

  function automatic logic [PCW-1:0] popcnt(input logic [NC-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NC; i++) popcnt = popcnt + PCW'(v[i]);
  endfunction

  // Time-ordered bit stream: history (oldest at bit 0) followed by the new
  // word. b[n-k] for word bit i is ext[NH+i-k], so earlier bits of the same
  // word feed later predictions directly (self-synchronising).
  assign ext = {rx_bits, hist_q};

  always_comb begin
    pred = '0;
    for (int i = 0; i < NC; i++)
      for (int k = 1; k < n_prbs; k++)
        pred[i] = pred[i] ^ (prbs_eqn[k] & ext[NH+i-k]);
  end

  assign errs       = rx_bits ^ pred;
  assign err_pc     = popcnt(errs);
  assign bad        = err_pc > PCW'(NC / 4);
  assign run_inc    = run_q + n_thresh'(1);
  assign lock_eff   = (lock_thresh == '0) ? n_thresh'(1) : lock_thresh;
  assign unlock_eff = (unlock_thresh == '0) ? n_thresh'(1) : unlock_thresh;
  assign err_sum    = {1'b0, err_bits_q} + (n_cnt+1)'(err_pc);
  assign tot_sum    = {1'b0, total_bits_q} + (n_cnt+1)'(NC);

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    run_d        = run_q;
    err_flags_d  = err_flags_q;
    err_bits_d   = err_bits_q;
    total_bits_d = total_bits_q;
    locked_d     = locked_q;
    loss_cnt_d   = loss_cnt_q;
    if (mode_q == MODE_RESET) begin
      state_d      = S_IDLE;
      hist_d       = '0;
      fill_d       = '0;
      run_d        = '0;
      err_flags_d  = '0;
      err_bits_d   = '0;
      total_bits_d = '0;
      locked_d     = 1'b0;
      loss_cnt_d   = '0;
    end else if (mode_q == MODE_FREEZE && state_q != S_IDLE) begin
      // Checked before the LOCKED branch so a freeze on the same edge as an
      // unlock threshold wins and loss_cnt is left alone.
      state_d = S_FROZEN;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_FILL;
          fill_d  = '0;
          run_d   = '0;
        end
        S_FROZEN: begin
          // History may be stale after a freeze: refill it from scratch.
          state_d  = S_FILL;
          fill_d   = '0;
          run_d    = '0;
          locked_d = 1'b0;
        end
        S_FILL: if (rx_valid) begin
          hist_d      = ext[NH+NC-1 -: NH];
          err_flags_d = '0;
          if (fill_q == NF'(FILL_WORDS - 1)) begin
            state_d = S_SEARCH;
            fill_d  = '0;
            run_d   = '0;
          end else begin
            fill_d = fill_q + NF'(1);
          end
        end
        S_SEARCH: if (rx_valid) begin
          hist_d      = ext[NH+NC-1 -: NH];
          err_flags_d = errs;
          if (errs != '0) begin
            run_d = '0;
          end else if (run_inc >= lock_eff) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
            run_d    = '0;
          end else begin
            run_d = run_inc;
          end
        end
        S_LOCKED: if (rx_valid) begin
          hist_d      = ext[NH+NC-1 -: NH];
          err_flags_d = errs;
          if (mode_q == MODE_RUN) begin
            err_bits_d   = err_sum[n_cnt] ? '1 : err_sum[n_cnt-1:0];
            total_bits_d = tot_sum[n_cnt] ? '1 : tot_sum[n_cnt-1:0];
          end
          if (!bad) begin
            run_d = '0;
          end else if (run_inc >= unlock_eff) begin
            state_d  = S_SEARCH;
            locked_d = 1'b0;
            run_d    = '0;
            if (loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + n_loss'(1);
          end else begin
            run_d = run_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      hist_q       <= '0;
      fill_q       <= '0;
      run_q        <= '0;
      err_flags_q  <= '0;
      err_bits_q   <= '0;
      total_bits_q <= '0;
      locked_q     <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= checker_mode;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      run_q        <= run_d;
      err_flags_q  <= err_flags_d;
      err_bits_q   <= err_bits_d;
      total_bits_q <= total_bits_d;
      locked_q     <= locked_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  assign err_flags  = err_flags_q;
  assign err_bits   = err_bits_q;
  assign total_bits = total_bits_q;
  assign locked     = locked_q;
  assign loss_cnt   = loss_cnt_q;
endmodule

// File: tb/tb_prbs_checker_multi.sv
// Testbench for prbs_checker_multi: directed sequence with a bit-serial
// reference model and an expectation queue popped one edge after each drive.
module tb_prbs_checker_multi;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] prbs_eqn;
  logic [1:0]  checker_mode;
  logic [15:0] rx_bits;
  logic        rx_valid;
  logic [7:0]  lock_thresh, unlock_thresh;
  logic [15:0] err_flags;
  logic [63:0] err_bits, total_bits;
  logic        locked;
  logic [15:0] loss_cnt;

  prbs_checker_multi #(.n_prbs(32), .n_channels(16), .n_cnt(64), .n_thresh(8), .n_loss(16)) dut (
    .clk(clk), .rst(rst), .prbs_eqn(prbs_eqn), .checker_mode(checker_mode),
    .rx_bits(rx_bits), .rx_valid(rx_valid), .lock_thresh(lock_thresh),
    .unlock_thresh(unlock_thresh), .err_flags(err_flags), .err_bits(err_bits),
    .total_bits(total_bits), .locked(locked), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] flags;
    logic [63:0] eb;
    logic [63:0] tb;
    logic        lk;
    logic [15:0] lc;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] eqn_v = 32'h0010_0002;
  logic [30:0] gen_h = 31'h1234_5678;  // generator history, bit 0 = newest
  logic [30:0] m_hist = '0;             // model history of received bits
  logic [15:0] e_flags = '0;
  logic [63:0] e_err = '0, e_tot = '0;
  logic        e_lock = 1'b0;
  logic [15:0] e_loss = '0;
  logic [63:0] all1 = '1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [63:0] sadd(input logic [63:0] a, input int b);
    logic [64:0] s;
    s = {1'b0, a} + 65'(b);
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
  endfunction

  // Bit-serial reference: each bit is predicted from the bits before it.
  function automatic void model(input logic [15:0] w, input logic [30:0] h,
                                output logic [15:0] f, output logic [30:0] nh);
    nh = h;
    for (int i = 0; i < 16; i++) begin
      f[i] = w[i] ^ (^(eqn_v[31:1] & nh));
      nh   = {nh[29:0], w[i]};
    end
  endfunction

  task automatic gen_word(output logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      w[i]  = ^(eqn_v[31:1] & gen_h);
      gen_h = {gen_h[29:0], w[i]};
    end
  endtask

  // Drive one word, push its expectation, pop and compare after the edge.
  task automatic step(input logic v, input logic [15:0] w, input bit fill,
                      input bit cnt, input bit frz);
    exp_t        e;
    logic [15:0] f;
    logic [30:0] nh;
    rx_valid = v;
    rx_bits  = w;
    if (v && !frz) begin
      model(w, m_hist, f, nh);
      m_hist = nh;
      if (fill) f = '0;
      e_flags = f;
      if (cnt) begin
        e_err = sadd(e_err, popc(f));
        e_tot = sadd(e_tot, 16);
      end
    end
    e.flags = e_flags; e.eb = e_err; e.tb = e_tot; e.lk = e_lock; e.lc = e_loss;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("err_flags",  err_flags,  e.flags);
    chk("err_bits",   err_bits,   e.eb);
    chk("total_bits", total_bits, e.tb);
    chk("locked",     locked,     e.lk);
    chk("loss_cnt",   loss_cnt,   e.lc);
  endtask

  // Feed PRBS words in SEARCH until the model sees lock_thresh clean words.
  task automatic relock();
    int          run = 0;
    logic [15:0] w, f;
    logic [30:0] nh;
    for (int n = 0; n < 30 && !e_lock; n++) begin
      gen_word(w);
      model(w, m_hist, f, nh);
      run = (f == '0) ? run + 1 : 0;
      if (run == 4) e_lock = 1'b1;
      step(1'b1, w, 1'b0, 1'b0, 1'b0);
    end
    chk("relock", locked, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] w, f, m;
    logic [30:0] nh;
    logic [63:0] snap_err, snap_tot;
    int          p;

    rst = 1'b1; prbs_eqn = eqn_v; checker_mode = 2'd0; rx_bits = '0; rx_valid = 1'b0;
    lock_thresh = 8'd4; unlock_thresh = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_flags", err_flags, 0);
    chk("rst_err", err_bits, 0);
    chk("rst_tot", total_bits, 0);
    chk("rst_lock", locked, 0);
    chk("rst_loss", loss_cnt, 0);

    // Align: two idle edges for the registered mode, 2 fill + 4 clean words.
    checker_mode = 2'd1;
    step(1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 2; n++) begin
      gen_word(w);
      step(1'b1, w, 1'b1, 1'b0, 1'b0);
    end
    for (int n = 0; n < 4; n++) begin
      gen_word(w);
      if (n == 3) e_lock = 1'b1;
      step(1'b1, w, 1'b0, 1'b0, 1'b0);
    end

    // Run 600 clean words.
    checker_mode = 2'd2;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      gen_word(w);
      step(1'b1, w, 1'b0, 1'b1, 1'b0);
    end
    chk("total_600", total_bits, 64'd9600);
    chk("err_600", err_bits, 0);

    // Single-bit injections, each feeding taps 1 and 20.
    for (int n = 0; n < 3; n++) begin
      p = (n == 0) ? 2 : (n == 1) ? 7 : 10;
      m = 16'h0001 << p;
      gen_word(w);
      step(1'b1, w ^ m, 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 3; j++) begin
        gen_word(w);
        step(1'b1, w, 1'b0, 1'b1, 1'b0);
      end
    end
    chk("err_inject", err_bits, 64'd9);
    chk("lock_inject", locked, 1);

    // Loss of lock: 10 random words, each with more than 4 errors.
    snap_tot = '0;
    for (int n = 0; n < 10; n++) begin
      for (int t = 0; t < 100; t++) begin
        w = 16'($urandom);
        model(w, m_hist, f, nh);
        if (popc(f) > 4) break;
      end
      if (n == 2) begin e_lock = 1'b0; e_loss = 16'd1; end
      step(1'b1, w, 1'b0, n < 3, 1'b0);
      if (n == 2) snap_tot = total_bits;
    end
    chk("loss_lock", locked, 0);
    chk("loss_cnt1", loss_cnt, 1);
    chk("loss_frozen_tot", total_bits, snap_tot);
    relock();
    for (int n = 0; n < 5; n++) begin
      gen_word(w);
      step(1'b1, w, 1'b0, 1'b1, 1'b0);
    end
    chk("resume_tot", total_bits, snap_tot + 64'd80);

    // Freeze: the word on the mode edge still counts, then everything holds.
    checker_mode = 2'd3;
    gen_word(w);
    step(1'b1, w, 1'b0, 1'b1, 1'b0);
    snap_err = err_bits; snap_tot = total_bits;
    for (int n = 0; n < 50; n++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b1);
    chk("frz_err", err_bits, snap_err);
    chk("frz_tot", total_bits, snap_tot);
    checker_mode = 2'd2;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    e_lock = 1'b0;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 2; n++) begin
      gen_word(w);
      step(1'b1, w, 1'b1, 1'b0, 1'b0);
    end
    relock();
    chk("frz_loss", loss_cnt, 1);

    // Valid gaps: only valid words advance total_bits.
    snap_tot = total_bits;
    for (int n = 0; n < 20; n++) begin
      if (n % 2 == 0) begin
        gen_word(w);
        step(1'b1, w, 1'b0, 1'b1, 1'b0);
      end else begin
        step(1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0);
      end
    end
    chk("gap_tot", total_bits, snap_tot + 64'd160);

    // Saturation of total_bits.
    force dut.total_bits_q = 64'hFFFF_FFFF_FFFF_FFF8;
    #1;
    release dut.total_bits_q;
    e_tot = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int n = 0; n < 2; n++) begin
      gen_word(w);
      step(1'b1, w, 1'b0, 1'b1, 1'b0);
      chk("sat_tot", total_bits, all1);
    end

    // Reset pulse mid-run.
    rst = 1'b1; rx_valid = 1'b1;
    gen_word(w); rx_bits = w;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_flags", err_flags, 0);
    chk("mrst_err", err_bits, 0);
    chk("mrst_tot", total_bits, 0);
    chk("mrst_lock", locked, 0);
    chk("mrst_loss", loss_cnt, 0);
    e_flags = '0; e_err = '0; e_tot = '0; e_lock = 1'b0; e_loss = '0;
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/prbs_checker_multi.md
# prbs_checker_multi

Parametrised multi-lane, self-synchronising PRBS checker for the digital core. It sits after the RX datapath (FFE/slicer output or raw ADC sign bits, selected upstream) and consumes one word of `n_channels` recovered bits per clock. It programs the PRBS polynomial at run time, self-aligns, and accumulates 64-bit error and total bit counters for JTAG readout. It also detects loss of lock and re-acquires lock automatically, counting each loss event.

## Interface
- `n_prbs`, 32: PRBS equation width; maximum supported tap delay is `n_prbs-1`.
- `n_channels`, 16: bits per input word (time-interleaved lanes).
- `n_cnt`, 64: width of the error and total bit counters.
- `n_thresh`, 8: width of the lock and unlock threshold inputs.
- `n_loss`, 16: width of the loss-of-lock event counter.

Ports (name, direction, width, meaning):
- `clk`  in  1  datapath clock (divided ADC clock domain).
- `rst`  in  1  synchronous, active-high reset.
- `prbs_eqn`  in  n_prbs  tap mask; bit k=1 means bit n-k is XORed into the prediction; bit 0 is ignored.
- `checker_mode`  in  2  0=RESET, 1=ALIGN, 2=RUN, 3=FREEZE; quasi-static JTAG value.
- `rx_bits`  in  n_channels  received word; bit 0 is the earliest bit in time.
- `rx_valid`  in  1  word qualifier.
- `lock_thresh`  in  n_thresh  number of consecutive error-free words required to declare lock; 0 is treated as 1.
- `unlock_thresh`  in  n_thresh  number of consecutive bad words required to declare loss of lock; 0 is treated as 1.
- `err_flags`  out  n_channels  per-bit error flags for the last valid word.
- `err_bits`  out  n_cnt  accumulated bit errors.
- `total_bits`  out  n_cnt  accumulated checked bits.
- `locked`  out  1  checker is aligned.
- `loss_cnt`  out  n_loss  number of lock→unlock transitions.

## Operation
- **Prediction.** For each bit n, prediction = XOR of b[n-k] over all k≥1 with `prbs_eqn[k]`=1. The history is a shift register of the last `n_prbs-1` received bits. The prediction is unrolled across the word, so bit i uses history bits and bits 0..i-1 of the same word. Error flag for bit i = b[i] XOR prediction[i].
- **FSM states.** IDLE, FILL, SEARCH, LOCKED, FROZEN.
  - IDLE: entered when `checker_mode`=0 or `rst`=1. Clears history, all counters, `err_flags`, `locked` and `loss_cnt`.
  - FILL: entered from IDLE when mode≠0. Shifts in ceil((n_prbs-1)/n_channels) valid words. `err_flags` are forced to 0. Then moves to SEARCH.
  - SEARCH: an error-free valid word increments the good-word run counter; any error clears it. When the run reaches `lock_thresh`, the FSM moves to LOCKED and `locked`=1.
  - LOCKED: in mode 2, counting is enabled. A "bad word" is a valid word whose popcount(errors) exceeds n_channels/4. Consecutive bad words increment the bad-run counter; any other valid word clears it. When the run reaches `unlock_thresh`, the FSM returns to SEARCH, sets `locked`=0 and increments `loss_cnt` (saturating). Counting stops until lock is re-acquired.
  - FROZEN: entered from any non-IDLE state when mode=3. All outputs hold and the history does not shift. When mode leaves 3, the FSM goes to FILL (stale history is discarded) and `locked`=0. This transition does not increment `loss_cnt`.
- **Counting.** Counting is enabled only when state=LOCKED, mode=2 and `rx_valid`=1.
  - `total_bits` += n_channels.
  - `err_bits` += popcount(`err_flags` of that word).
  - Both counters saturate at all-ones; each saturates independently.
- **Mode transitions.** Mode 1→2 while LOCKED starts counting on the next valid word with no realignment. Mode 2→1 stops counting and keeps lock.
- **Invalid words.** When `rx_valid`=0, history, run counters, counters and `err_flags` all hold.
- **Equation changes.** A change of `prbs_eqn` is legal only in IDLE. Otherwise the behaviour is that of a corrupted stream: the FSM loses lock and re-searches.

## Timing
- `rx_bits` is sampled at edge k. `err_flags`, the counters and `locked` reflect that word after edge k (1-cycle latency). There is no combinational input-to-output path.
- `checker_mode` is registered internally. A mode change seen at edge k takes effect on words sampled from edge k+1.
- Reset values: all outputs are 0. The FSM is in IDLE.
- `rst` asserted mid-operation clears everything at the next edge, regardless of mode.
- Simultaneous bad-run threshold and mode→3 on the same edge: FREEZE wins and `loss_cnt` is unchanged.

## Test plan
- **Clean lock and count.** PRBS with taps 1 and 20 (`prbs_eqn`=0x00100002), n_channels=16, `lock_thresh`=4, mode 1 then mode 2 for 600 valid words.
  - `locked`=1 after 2 fill words + 4 good words.
  - `total_bits`=9600, `err_bits`=0.
- **Injected errors.** Flip 3 single bits in separate words during RUN.
  - Each flip raises its own error flag plus one flag per tap position it feeds (taps 1 and 20).
  - `err_bits`=9 (3 errors × 3 flags).
  - `locked` stays 1.
- **Loss of lock.** `unlock_thresh`=3, then replace the stream with random data for 10 words.
  - `locked`=0 after the 3rd bad word; `loss_cnt`=1.
  - Counters freeze.
  - Restore the PRBS stream: relock after 4 good words and counting resumes.
- **Freeze/readout.** Switch to mode 3 mid-run and apply 50 random words.
  - Counters and `err_flags` are unchanged.
  - Return to mode 2: FILL then SEARCH, `loss_cnt` unchanged.
- **Valid gaps and saturation.** Toggle `rx_valid` every cycle: `total_bits` advances by 16 per valid word only. Preload the counter via a force to 2^64-8 and run one word: the counter sticks at all-ones.
- **Reset mid-run.** Pulse `rst` for 1 cycle during LOCKED/RUN: all outputs are 0 on the next edge and the FSM is in IDLE.
